// File: rtl/phase_conditioner_pkg.sv
// Shared types and defaults for the phase-sensor conditioning block.
`timescale 1ns/1ps
package phase_conditioner_pkg;

   typedef enum logic [1:0] {
      NO_SIGNAL = 2'd0,
      ACQUIRE   = 2'd1,
      LOCKED    = 2'd2
   } lock_state_e;

   localparam int unsigned FILTER_LEN_DEFAULT = 8;
   localparam int unsigned TIMEOUT_DEFAULT    = 2_000_000;
   localparam int unsigned CNT_W              = 32;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/sync_filter.sv
// Two-flop synchronizer followed by a consecutive-sample glitch filter;
// rise pulses in the same cycle the filtered level goes 0->1.
`timescale 1ns/1ps
module sync_filter
   import phase_conditioner_pkg::*;
#(
   parameter int unsigned FILTER_LEN = FILTER_LEN_DEFAULT
) (
   input  logic clock,
   input  logic reset_n,
   input  logic din,
   output logic dout,
   output logic rise
);

   localparam int unsigned FCNT_W = 8;

   logic [1:0]        sync_q, sync_d;
   logic [FCNT_W-1:0] cnt_q, cnt_d;
   logic              level_q, level_d;
   logic              rise_q, rise_d;

   // Count samples disagreeing with the level; any agreeing sample restarts the run.
   always_comb begin
      sync_d  = {sync_q[0], din};
      level_d = level_q;
      rise_d  = 1'b0;
      cnt_d   = '0;
      if (sync_q[1] != level_q) begin
         if (cnt_q == FCNT_W'(FILTER_LEN - 1)) begin
            level_d = ~level_q;
            rise_d  = ~level_q;
         end else begin
            cnt_d = cnt_q + FCNT_W'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
      end
   end

   assign dout = level_q;
   assign rise = rise_q;

endmodule

// File: rtl/phase_conditioner.sv
// Phase-sensor conditioner: filtered level, rising-edge pulse, lock tracking
// with loss-of-signal timeout. Period measurement built only with PHASE_PERIOD_MEAS_EN.
`timescale 1ns/1ps
module phase_conditioner
   import phase_conditioner_pkg::*;
#(
   parameter int unsigned FILTER_LEN = FILTER_LEN_DEFAULT,
   parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             phase_raw,
   input  logic             enable,
   output logic             phase_signal,
   output logic             phase_edge,
   output logic [CNT_W-1:0] period_out,
   output logic             period_valid,
   output logic             phase_lost,
   output logic [1:0]       lock_state
);

   lock_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             lost_q, lost_d;
   logic             rise;
   logic             tracking;

   sync_filter #(
      .FILTER_LEN(FILTER_LEN)
   ) u_sync_filter (
      .clock  (clock),
      .reset_n(reset_n),
      .din    (phase_raw),
      .dout   (phase_signal),
      .rise   (rise)
   );

   assign phase_edge = rise & enable;
   assign cnt_inc    = sat_inc(cnt_q);
   assign tracking   = (state_q == ACQUIRE) || (state_q == LOCKED);

   // Lock tracking; an edge takes priority over a coincident timeout.
   always_comb begin
      state_d = NO_SIGNAL;
      cnt_d   = cnt_inc;
      lost_d  = lost_q;
      case (state_q)
         NO_SIGNAL, ACQUIRE, LOCKED: state_d = state_q;
         default:                    state_d = NO_SIGNAL;
      endcase
      if (!enable) begin
         state_d = NO_SIGNAL;
         cnt_d   = '0;
         lost_d  = 1'b0;
      end else if (phase_edge) begin
         cnt_d  = '0;
         lost_d = 1'b0;
         case (state_q)
            NO_SIGNAL:       state_d = ACQUIRE;
            ACQUIRE, LOCKED: state_d = LOCKED;
            default:         state_d = NO_SIGNAL;
         endcase
      end else if (tracking && (cnt_inc >= CNT_W'(TIMEOUT))) begin
         state_d = NO_SIGNAL;
         cnt_d   = '0;
         lost_d  = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= NO_SIGNAL;
         cnt_q   <= '0;
         lost_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lost_q  <= lost_d;
      end
   end

   assign phase_lost = lost_q;
   assign lock_state = 2'(state_q);

`ifdef PHASE_PERIOD_MEAS_EN
   logic [CNT_W-1:0] period_q, period_d;
   logic             pvalid_q, pvalid_d;

   // Period is the inclusive cycle count between consecutive tracked edges.
   always_comb begin
      period_d = period_q;
      pvalid_d = 1'b0;
      if (phase_edge && tracking) begin
         period_d = cnt_inc;
         pvalid_d = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         period_q <= '0;
         pvalid_q <= 1'b0;
      end else begin
         period_q <= period_d;
         pvalid_q <= pvalid_d;
      end
   end

   assign period_out   = period_q;
   assign period_valid = pvalid_q;
`else
   assign period_out   = '0;
   assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_phase_conditioner.sv
// Self-checking bench for phase_conditioner: cycle-by-cycle reference model
// plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_phase_conditioner;

   localparam int unsigned F = 8;
   localparam int unsigned T = 5000;
   localparam longint      SAT = 64'h0000_0000_FFFF_FFFF;

   logic        clock     = 1'b0;
   logic        reset_n   = 1'b0;
   logic        phase_raw = 1'b0;
   logic        enable    = 1'b0;
   logic        phase_signal;
   logic        phase_edge;
   logic [31:0] period_out;
   logic        period_valid;
   logic        phase_lost;
   logic [1:0]  lock_state;

   int tests = 0;
   int fails = 0;

   phase_conditioner #(
      .FILTER_LEN(F),
      .TIMEOUT   (T)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .phase_raw   (phase_raw),
      .enable      (enable),
      .phase_signal(phase_signal),
      .phase_edge  (phase_edge),
      .period_out  (period_out),
      .period_valid(period_valid),
      .phase_lost  (phase_lost),
      .lock_state  (lock_state)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Reference model: raw samples delayed two clocks, level flips when the
   // last F delayed samples all disagree with it; lock tracked by cycles since edge.
   bit     rawq[$];
   bit     win[$];
   bit     m_level, m_rise, m_lost, m_pv;
   int     m_state;
   longint m_since, m_period;

   task automatic model_reset();
      rawq.delete();
      win.delete();
      m_level = 0; m_rise = 0; m_lost = 0; m_pv = 0;
      m_state = 0; m_since = 0; m_period = 0;
   endtask

   task automatic model_step();
      bit     eff, edge_seen, all_diff;
      longint inc;
      if (!reset_n) begin
         model_reset();
         return;
      end
      eff = (rawq.size() >= 2) ? rawq[rawq.size()-2] : 1'b0;
      rawq.push_back(phase_raw);
      if (rawq.size() > 2) void'(rawq.pop_front());

      edge_seen = m_rise && enable;
      inc  = (m_since >= SAT) ? SAT : m_since + 1;
      m_pv = 0;
      if (!enable) begin
         m_state = 0; m_lost = 0; m_since = 0;
      end else if (edge_seen) begin
         if (m_state != 0) begin
            m_period = inc;
            m_pv     = 1;
         end
         m_state = (m_state == 0) ? 1 : 2;
         m_lost  = 0;
         m_since = 0;
      end else if (m_state != 0 && inc >= T) begin
         m_state = 0; m_lost = 1; m_since = 0;
      end else begin
         m_since = inc;
      end

      win.push_back(eff);
      if (win.size() > F) void'(win.pop_front());
      all_diff = (win.size() == F);
      foreach (win[i]) if (win[i] == m_level) all_diff = 0;
      m_rise = 0;
      if (all_diff) begin
         m_level = !m_level;
         m_rise  = m_level;
      end
   endtask

   initial model_reset();

   // Per-cycle comparison against the model.
   always @(posedge clock) begin
      longint exp_per;
      bit     exp_pv;
      model_step();
      #1;
`ifdef PHASE_PERIOD_MEAS_EN
      exp_per = m_period;
      exp_pv  = m_pv;
`else
      exp_per = 0;
      exp_pv  = 0;
`endif
      check("cyc_phase_signal", phase_signal, m_level);
      check("cyc_phase_edge",   phase_edge,   m_rise && enable);
      check("cyc_lock_state",   lock_state,   m_state);
      check("cyc_phase_lost",   phase_lost,   m_lost);
      check("cyc_period_valid", period_valid, exp_pv);
      check("cyc_period_out",   period_out,   exp_per);
   end

   task automatic wait_edge(input int max_cyc);
      bit ok = 0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clock);
         if (phase_edge) begin
            ok = 1;
            break;
         end
      end
      check("wait_phase_edge", ok, 1);
   endtask

   initial begin
      bit seen;
      int hold;
      bit meas;
`ifdef PHASE_PERIOD_MEAS_EN
      meas = 1;
`else
      meas = 0;
`endif
      #1;
      check("rst_phase_signal", phase_signal, 0);
      check("rst_phase_edge",   phase_edge,   0);
      check("rst_lock_state",   lock_state,   0);
      check("rst_phase_lost",   phase_lost,   0);
      check("rst_period_valid", period_valid, 0);
      check("rst_period_out",   period_out,   0);

      repeat (3) @(negedge clock);
      reset_n = 1;
      enable  = 1;
      repeat (20) @(negedge clock);

      // Clean rise: level and edge appear exactly 2+F = 10 clocks later.
      phase_raw = 1;
      repeat (9) @(negedge clock);
      check("lat_before", phase_signal, 0);
      @(negedge clock);
      check("lat_signal", phase_signal, 1);
      check("lat_edge",   phase_edge,   1);
      @(negedge clock);
      check("lat_edge_one_cycle", phase_edge, 0);
      check("lat_acquire",        lock_state, 1);

      phase_raw = 0;
      repeat (20) @(negedge clock);
      check("fall_signal", phase_signal, 0);

      // Glitch one sample shorter than the filter.
      phase_raw = 1;
      repeat (7) @(negedge clock);
      phase_raw = 0;
      seen = 0;
      repeat (20) begin
         @(negedge clock);
         if (phase_signal || phase_edge) seen = 1;
      end
      check("glitch_rejected", seen, 0);

      enable = 0;
      repeat (2) @(negedge clock);
      check("enable_low_state", lock_state, 0);
      enable = 1;

      // Edges every 1000 cycles.
      for (int e = 1; e <= 4; e++) begin
         phase_raw = 1;
         repeat (11) @(negedge clock);
         check("train_state", lock_state, (e == 1) ? 1 : 2);
         if (e >= 2) begin
            check("train_period_valid", period_valid, meas);
            check("train_period_out",   period_out,   meas ? 1000 : 0);
         end
         repeat (489) @(negedge clock);
         phase_raw = 0;
         repeat (500) @(negedge clock);
      end

      // Loss of signal T+1 cycles after the last edge cycle.
      phase_raw = 1;
      wait_edge(40);
      repeat (T) @(negedge clock);
      check("pre_timeout_lost",  phase_lost, 0);
      check("pre_timeout_state", lock_state, 2);
      @(negedge clock);
      check("timeout_lost",  phase_lost, 1);
      check("timeout_state", lock_state, 0);
      phase_raw = 0;
      repeat (20) @(negedge clock);
      phase_raw = 1;
      wait_edge(40);
      check("lost_held_at_edge", phase_lost, 1);
      @(negedge clock);
      check("relock_lost",  phase_lost, 0);
      check("relock_state", lock_state, 1);

      phase_raw = 0;
      repeat (20) @(negedge clock);
      phase_raw = 1;
      wait_edge(40);
      @(negedge clock);
      check("locked_again", lock_state, 2);
      enable = 0;
      @(negedge clock);
      check("disable_state", lock_state, 0);
      check("disable_edge",  phase_edge, 0);
      enable = 1;

      // Asynchronous reset while the filter is mid-count.
      phase_raw = 0;
      repeat (5) @(negedge clock);
      #2 reset_n = 0;
      #1;
      check("async_rst_signal", phase_signal, 0);
      check("async_rst_state",  lock_state,   0);
      check("async_rst_pvalid", period_valid, 0);
      check("async_rst_period", period_out,   0);
      @(negedge clock);
      reset_n   = 1;
      phase_raw = 1;
      repeat (9) @(negedge clock);
      check("post_rst_before", phase_signal, 0);
      @(negedge clock);
      check("post_rst_signal", phase_signal, 1);
      check("post_rst_edge",   phase_edge,   1);

      // Randomized levels, enable drops and occasional resets.
      repeat (300) begin
         phase_raw = 1'($urandom_range(0, 1));
         enable    = ($urandom_range(0, 9) != 0);
         hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7))
                                            : int'($urandom_range(8, 60));
         if ($urandom_range(0, 99) == 0) begin
            #2 reset_n = 0;
            @(negedge clock);
            reset_n = 1;
         end
         repeat (hold) @(negedge clock);
      end

      repeat (5) @(negedge clock);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/phase_conditioner.md
PHASE_CONDITIONER -- requirements
Module: phase_conditioner

Interface
REQ-001 Parameter FILTER_LEN, default 8, number of consecutive stable synchronized samples required to change the filtered level (legal range 1..255).
REQ-002 Parameter TIMEOUT, default 2_000_000, clock cycles without a filtered rising edge before loss of signal is declared.
REQ-003 clock  input  1  system clock; every flop of the block is on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 phase_raw  input  1  raw phase-sensor level, asynchronous to clock.
REQ-006 enable  input  1  level; high enables edge output and lock tracking.
REQ-007 phase_signal  output  1  synchronized, glitch-filtered level; feeds the calibration FSM phase input.
REQ-008 phase_edge  output  1  one-cycle pulse on each filtered rising edge while enabled.
REQ-009 period_out  output  32  cycles between the last two phase_edge pulses.
REQ-010 period_valid  output  1  one-cycle pulse when period_out is updated.
REQ-011 phase_lost  output  1  level; high while no edge has arrived within TIMEOUT.
REQ-012 lock_state  output  2  current state encoding: NO_SIGNAL=0, ACQUIRE=1, LOCKED=2.

Function
REQ-013 phase_raw shall pass through a 2-flop synchronizer before any other use.
REQ-014 phase_signal shall toggle only after FILTER_LEN consecutive synchronized samples differ from its current value; any matching sample clears the stability count.
REQ-015 Latency from a clean phase_raw change to the phase_signal change shall be exactly 2 + FILTER_LEN cycles; pulses shorter than FILTER_LEN cycles shall not appear.
REQ-016 phase_edge shall be high in the same cycle phase_signal goes 0->1, and only when enable is high.
REQ-017 An edge counter shall reset to 0 on every phase_edge, otherwise increment, saturating at 2^32-1.
REQ-018 On phase_edge in ACQUIRE or LOCKED, period_out shall load counter+1 (saturated) and period_valid shall pulse in the following cycle.
REQ-019 States: NO_SIGNAL --phase_edge--> ACQUIRE --phase_edge--> LOCKED; LOCKED stays LOCKED on phase_edge.
REQ-020 In ACQUIRE or LOCKED, the counter reaching TIMEOUT without an edge shall force NO_SIGNAL and set phase_lost in that cycle.
REQ-021 phase_lost shall clear on the next phase_edge; the edge counter is also cleared when NO_SIGNAL is entered.
REQ-022 enable low shall force NO_SIGNAL, clear phase_lost and the edge counter, and suppress phase_edge/period_valid; the filter keeps running.
REQ-023 Timeout and phase_edge in the same cycle: the edge wins (no phase_lost, state advances normally).
REQ-024 A state register value outside the legal encodings shall return to NO_SIGNAL on the next cycle.

Reset
REQ-025 On reset_n low: synchronizer, filter count, phase_signal, phase_edge, period_out, period_valid and phase_lost = 0, and lock_state = NO_SIGNAL, immediately and independent of clock.
REQ-026 Reset release mid-pulse shall treat phase_raw as a fresh level; the first edge still requires the full filter latency.

Configuration
REQ-027 Macro PHASE_PERIOD_MEAS_EN defined: period_out/period_valid behave as REQ-018.
REQ-028 Macro PHASE_PERIOD_MEAS_EN undefined: period registers are removed, period_out is tied to 0 and period_valid to 0; the timeout, state machine and edge path are unchanged.

Structure
REQ-029 A shared package shall hold the lock-state enum (NO_SIGNAL, ACQUIRE, LOCKED) and the default FILTER_LEN/TIMEOUT constants.
REQ-030 The synchronizer plus glitch filter shall be the sub-module sync_filter (parameter FILTER_LEN; ports clock, reset_n, din, dout, rise).

Verification
REQ-031 With reset released and FILTER_LEN=8, phase_raw 0->1 held -> phase_signal and phase_edge are high 10 cycles later, and phase_edge lasts 1 cycle.
REQ-032 With FILTER_LEN=8, a 7-cycle high glitch on phase_raw -> no phase_signal change and no phase_edge.
REQ-033 Clean edges every 1000 cycles -> ACQUIRE after edge 1, LOCKED after edge 2, period_out=1000 and period_valid pulses each edge from edge 2 onward.
REQ-034 With TIMEOUT=5000 and edges stopped while LOCKED -> phase_lost rises and lock_state=NO_SIGNAL 5000 cycles after the last edge; the next edge clears phase_lost and enters ACQUIRE.
REQ-035 Toggling enable low mid-LOCKED and asserting reset_n low mid-filter -> lock_state=0, outputs 0 immediately; after reset release the edge path behaves as REQ-031.
REQ-036 Build without PHASE_PERIOD_MEAS_EN and rerun the REQ-033 scenario -> period_out stays 0, period_valid never pulses, and lock_state sequence is identical.
